// File: rtl/csr_trap_csr_trap_ctrl.sv


// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//
// Trap / mret sequencer sitting between the commit stage and the CSR file.
//
// On an accepted exception it:
//    1. writes mepc
//    2. writes mcause
//    3. writes mtval (only when TRAP_TVAL_EN is defined)
//    4. reads mtvec
//    5. emits a one-cycle redirect to the trap vector.
//
// On an accepted mret it reads mepc and emits a one-cycle redirect to it.
// The pipeline is held (io_stall) for the whole sequence. New requests are
// only looked at in IDLE; anything presented in another state is dropped.
//
// Configuration macro:
//    TRAP_TVAL_EN - when defined, the mtval write state is present and
//                   io_exc_tval is used. When undefined, mcause is followed
//                   directly by the mtvec read and mtval is never written.
//
// Ports:
//    clock            sole clock, rising edge
//    reset            synchronous active-high reset
//    io_exc_valid     exception request from commit
//    io_exc_pc        faulting PC
//    io_exc_cause     cause (bit 63 = interrupt)
//    io_exc_tval      trap value
//    io_mret_valid    mret request from commit
//    io_csr_wen       CSR write strobe
//    io_csr_addr      CSR address for the current write/read
//    io_csr_wdata     CSR write data
//    io_csr_rdata     combinational CSR read data for io_csr_addr
//    io_stall         pipeline hold while not IDLE
//    io_redir_valid   one-cycle redirect pulse
//    io_redir_target  redirect PC; holds its last value between pulses
// ---------------------------------------------------------------------------
module csr_trap_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_exc_valid,
   input  logic [63:0] io_exc_pc,
   input  logic [63:0] io_exc_cause,
   input  logic [63:0] io_exc_tval,
   input  logic        io_mret_valid,
   output logic        io_csr_wen,
   output logic [11:0] io_csr_addr,
   output logic [63:0] io_csr_wdata,
   input  logic [63:0] io_csr_rdata,
   output logic        io_stall,
   output logic        io_redir_valid,
   output logic [63:0] io_redir_target
);

   localparam logic [11:0] ADDR_MTVEC  = 12'h305;
   localparam logic [11:0] ADDR_MEPC   = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE = 12'h342;
   localparam logic [11:0] ADDR_MTVAL  = 12'h343;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_EPC   = 3'd1,
      W_CAUSE = 3'd2,
      W_TVAL  = 3'd3,
      RD_TVEC = 3'd4,
      RD_EPC  = 3'd5,
      REDIR   = 3'd6
   } state_t;

   state_t      state_reg, state_next;
   logic [63:0] pc_reg, pc_next;
   logic [63:0] cause_reg, cause_next;
   logic [63:0] target_reg, target_next;

`ifdef TRAP_TVAL_EN
   logic [63:0] tval_reg, tval_next;
`else
   // The trap value is not needed in this build; reduce it so the input
   // is visibly consumed and nothing is left dangling.
   logic unused_tval;
   assign unused_tval = ^io_exc_tval;
`endif

   // Trap vector computation from the mtvec read data.
   // Vectored mode (mode field == 1) only applies to interrupts; the offset
   // is 4 * cause[5:0] and the sum wraps naturally at 64 bits.
   logic [63:0] tvec_base;
   logic [63:0] tvec_offset;
   logic        tvec_vectored;
   logic [63:0] tvec_target;

   assign tvec_base     = {io_csr_rdata[63:2], 2'b00};
   assign tvec_offset   = {56'd0, cause_reg[5:0], 2'b00};
   assign tvec_vectored = (io_csr_rdata[1:0] == 2'b01) && cause_reg[63];
   assign tvec_target   = tvec_vectored ? (tvec_base + tvec_offset) : tvec_base;

   // ------------------------------------------------------------------
   // State and data registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= IDLE;
         pc_reg     <= '0;
         cause_reg  <= '0;
         target_reg <= '0;
`ifdef TRAP_TVAL_EN
         tval_reg   <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         cause_reg  <= cause_next;
         target_reg <= target_next;
`ifdef TRAP_TVAL_EN
         tval_reg   <= tval_next;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      cause_next     = cause_reg;
      target_next    = target_reg;
`ifdef TRAP_TVAL_EN
      tval_next      = tval_reg;
`endif
      io_csr_wen     = 1'b0;
      io_csr_addr    = '0;
      io_csr_wdata   = '0;
      io_stall       = 1'b1;
      io_redir_valid = 1'b0;

      case (state_reg)
         IDLE: begin
            io_stall = 1'b0;
            // Exception has priority; a simultaneous mret is dropped.
            if (io_exc_valid) begin
               pc_next    = io_exc_pc;
               cause_next = io_exc_cause;
`ifdef TRAP_TVAL_EN
               tval_next  = io_exc_tval;
`endif
               state_next = W_EPC;
            end else if (io_mret_valid) begin
               state_next = RD_EPC;
            end
         end

         W_EPC: begin
            io_csr_wen   = 1'b1;
            io_csr_addr  = ADDR_MEPC;
            io_csr_wdata = pc_reg;
            state_next   = W_CAUSE;
         end

         W_CAUSE: begin
            io_csr_wen   = 1'b1;
            io_csr_addr  = ADDR_MCAUSE;
            io_csr_wdata = cause_reg;
`ifdef TRAP_TVAL_EN
            state_next   = W_TVAL;
`else
            state_next   = RD_TVEC;
`endif
         end

`ifdef TRAP_TVAL_EN
         W_TVAL: begin
            io_csr_wen   = 1'b1;
            io_csr_addr  = ADDR_MTVAL;
            io_csr_wdata = tval_reg;
            state_next   = RD_TVEC;
         end
`else
         // Unreachable in this build; fall back to IDLE if ever entered.
         W_TVAL: begin
            state_next = IDLE;
         end
`endif

         RD_TVEC: begin
            io_csr_addr = ADDR_MTVEC;
            target_next = tvec_target;
            state_next  = REDIR;
         end

         RD_EPC: begin
            io_csr_addr = ADDR_MEPC;
            target_next = {io_csr_rdata[63:1], 1'b0};
            state_next  = REDIR;
         end

         REDIR: begin
            io_redir_valid = 1'b1;
            state_next     = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Target is a register so it holds between redirect pulses.
   assign io_redir_target = target_reg;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl
//
// Bench for csr_trap_ctrl. A small CSR stub answers reads of mtvec/mepc from
// bench-owned values; a negedge monitor logs every CSR write and redirect
// with its cycle number. Each transaction is then compared against what
// the trap rules say should happen: the list of CSR writes, the redirect
// target, the latency and the number of stalled cycles.
// Directed vectors come from a table; randomized transactions use a
// behavioural target model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csr_trap_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_exc_valid;
   logic [63:0] io_exc_pc;
   logic [63:0] io_exc_cause;
   logic [63:0] io_exc_tval;
   logic        io_mret_valid;
   logic        io_csr_wen;
   logic [11:0] io_csr_addr;
   logic [63:0] io_csr_wdata;
   logic [63:0] io_csr_rdata;
   logic        io_stall;
   logic        io_redir_valid;
   logic [63:0] io_redir_target;

`ifdef TRAP_TVAL_EN
   localparam bit TVAL_EN = 1'b1;
`else
   localparam bit TVAL_EN = 1'b0;
`endif
   localparam int EXC_LAT  = TVAL_EN ? 5 : 4;
   localparam int MRET_LAT = 2;
   localparam int INJ_REDIR = 99;   // inject a request in the redirect cycle

   csr_trap_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .io_exc_valid    (io_exc_valid),
      .io_exc_pc       (io_exc_pc),
      .io_exc_cause    (io_exc_cause),
      .io_exc_tval     (io_exc_tval),
      .io_mret_valid   (io_mret_valid),
      .io_csr_wen      (io_csr_wen),
      .io_csr_addr     (io_csr_addr),
      .io_csr_wdata    (io_csr_wdata),
      .io_csr_rdata    (io_csr_rdata),
      .io_stall        (io_stall),
      .io_redir_valid  (io_redir_valid),
      .io_redir_target (io_redir_target)
   );

   always #5 clock = ~clock;

   // CSR stub: read values are owned by the bench.
   logic [63:0] env_mtvec = 64'd0;
   logic [63:0] env_mepc  = 64'd0;
   always_comb begin
      io_csr_rdata = 64'd0;
      if (io_csr_addr == 12'h305) io_csr_rdata = env_mtvec;
      else if (io_csr_addr == 12'h341) io_csr_rdata = env_mepc;
   end

   // Cycle counter and monitor.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bit          mon_en = 1'b0;
   logic [11:0] wr_addr_q[$];
   logic [63:0] wr_data_q[$];
   int          wr_cyc_q[$];
   logic [63:0] rd_tgt_q[$];
   int          rd_cyc_q[$];
   int          stall_cnt = 0;
   int          zero_viol = 0;

   always @(negedge clock) begin
      if (mon_en) begin
         if (io_csr_wen) begin
            wr_addr_q.push_back(io_csr_addr);
            wr_data_q.push_back(io_csr_wdata);
            wr_cyc_q.push_back(cyc);
         end
         if (io_redir_valid) begin
            rd_tgt_q.push_back(io_redir_target);
            rd_cyc_q.push_back(cyc);
         end
         if (io_stall) stall_cnt <= stall_cnt + 1;
         // In IDLE and REDIR the CSR bus must be quiet; no redirect in IDLE.
         if ((!io_stall || io_redir_valid) &&
             (io_csr_wen || io_csr_addr != 12'd0 || io_csr_wdata != 64'd0))
            zero_viol <= zero_viol + 1;
         if (!io_stall && io_redir_valid)
            zero_viol <= zero_viol + 1;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Behavioural reference for the redirect target.
   function automatic logic [63:0] model_target(input bit is_exc, input logic [63:0] cause,
                                                input logic [63:0] csr);
      logic [63:0] base;
      if (!is_exc) return csr - (csr % 2);
      base = csr - (csr % 4);
      if ((csr % 4) == 1 && cause >= 64'h8000_0000_0000_0000)
         return base + 64'(4 * (cause % 64));
      return base;
   endfunction

   typedef struct {
      bit          exc;
      bit          mret;
      logic [63:0] pc;
      logic [63:0] cause;
      logic [63:0] tval;
      logic [63:0] csr;        // mtvec for exceptions, mepc for mret
      logic [63:0] exp_target;
      int          inj;        // 0: none, n: extra request n cycles after accept
   } vec_t;

   // Starts at #1 after a rising edge with the DUT in IDLE, ends the same
   // way on the first IDLE cycle after the redirect.
   task automatic run_txn(input vec_t v, input int idx);
      int          acc, w0, r0, s0, z0, lat, inj, ne, nw, nr, lim;
      logic [11:0] ea[3];
      logic [63:0] ed[3];
      bit          is_exc;
      is_exc = v.exc;
      lat    = is_exc ? EXC_LAT : MRET_LAT;
      inj    = (v.inj == INJ_REDIR) ? lat : v.inj;
      ne     = 0;
      if (is_exc) begin
         ea[0] = 12'h341; ed[0] = v.pc;
         ea[1] = 12'h342; ed[1] = v.cause;
         ea[2] = 12'h343; ed[2] = v.tval;
         ne    = TVAL_EN ? 3 : 2;
         env_mtvec = v.csr;
      end else begin
         env_mepc = v.csr;
      end
      w0 = wr_addr_q.size(); r0 = rd_tgt_q.size(); s0 = stall_cnt; z0 = zero_viol;
      acc = cyc;
      io_exc_valid  = v.exc;
      io_mret_valid = v.mret;
      io_exc_pc     = v.pc;
      io_exc_cause  = v.cause;
      io_exc_tval   = v.tval;
      for (int i = 1; i <= 25; i++) begin
         @(posedge clock); #1;
         io_exc_valid  = 1'b0;
         io_mret_valid = 1'b0;
         if (i == inj) begin
            io_exc_valid  = 1'b1;
            io_mret_valid = 1'b1;
            io_exc_pc     = ~v.pc;
            io_exc_cause  = 64'd3;
            io_exc_tval   = 64'h55;
         end
         if (rd_tgt_q.size() > r0) break;
      end
      io_exc_valid  = 1'b0;
      io_mret_valid = 1'b0;
      nw = wr_addr_q.size() - w0;
      nr = rd_tgt_q.size() - r0;
      check($sformatf("t%0d write_count", idx), 64'(nw), 64'(ne));
      lim = (nw < ne) ? nw : ne;
      for (int j = 0; j < lim; j++) begin
         check($sformatf("t%0d w%0d addr", idx, j), 64'(wr_addr_q[w0+j]), 64'(ea[j]));
         check($sformatf("t%0d w%0d data", idx, j), wr_data_q[w0+j], ed[j]);
         check($sformatf("t%0d w%0d cycle", idx, j), 64'(wr_cyc_q[w0+j] - acc), 64'(j + 1));
      end
      check($sformatf("t%0d redirect_count", idx), 64'(nr), 64'd1);
      if (nr >= 1) begin
         check($sformatf("t%0d target", idx), rd_tgt_q[r0], v.exp_target);
         check($sformatf("t%0d latency", idx), 64'(rd_cyc_q[r0] - acc), 64'(lat));
      end
      check($sformatf("t%0d stall_cycles", idx), 64'(stall_cnt - s0), 64'(lat));
      check($sformatf("t%0d idle_redir_quiet", idx), 64'(zero_viol - z0), 64'd0);
      $display("txn %0d %s pc=%h cause=%h csr=%h -> target=%h lat=%0d inj=%0d",
               idx, is_exc ? "exc " : "mret", v.pc, v.cause, v.csr, v.exp_target, lat, inj);
   endtask

   vec_t tbl[9];
   vec_t rv;

   initial begin
      int          acc, w0, r0, late;
      int          kind;
      // Directed vectors: {exc, mret, pc, cause, tval, csr, expected target, inject}
      tbl[0] = '{1'b1, 1'b0, 64'h8000_0010, 64'd2, 64'hdead, 64'h8000_1000, 64'h8000_1000, 0};
      tbl[1] = '{1'b1, 1'b0, 64'h8000_0020, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_1001, 64'h8000_101C, 0};
      tbl[2] = '{1'b1, 1'b0, 64'h8000_0020, 64'h7, 64'h1, 64'h8000_1001, 64'h8000_1000, 0};
      tbl[3] = '{1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h8000_0015, 64'h8000_0014, 0};
      // both requests: exception wins; a second exception in W_CAUSE is ignored
      tbl[4] = '{1'b1, 1'b1, 64'h1234, 64'd5, 64'h77, 64'h2000, 64'h2000, 2};
      // vectored offset wraps modulo 2^64
      tbl[5] = '{1'b1, 1'b0, 64'h40, 64'h8000_0000_0000_003F, 64'h9, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_00F8, 0};
      // mode 3 is not vectored; request in the redirect cycle is ignored
      tbl[6] = '{1'b1, 1'b0, 64'h88, 64'h8000_0000_0000_0002, 64'h4, 64'h4003, 64'h4000, INJ_REDIR};
      // next IDLE cycle is accepted (runs back-to-back with the previous one)
      tbl[7] = '{1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h3, 64'h2, INJ_REDIR};
      tbl[8] = '{1'b1, 1'b0, 64'hABCD_0000, 64'h8000_0000_0000_0000, 64'hBEEF, 64'h1_0000_0001, 64'h1_0000_0000, 0};

      reset = 1'b1;
      io_exc_valid = 1'b0; io_mret_valid = 1'b0;
      io_exc_pc = '0; io_exc_cause = '0; io_exc_tval = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset wen",    64'(io_csr_wen), 64'd0);
      check("reset addr",   64'(io_csr_addr), 64'd0);
      check("reset wdata",  io_csr_wdata, 64'd0);
      check("reset stall",  64'(io_stall), 64'd0);
      check("reset redir",  64'(io_redir_valid), 64'd0);
      check("reset target", io_redir_target, 64'd0);
      @(posedge clock); #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 9; i++) run_txn(tbl[i], i);

      // Reset during W_CAUSE: sequence aborts, no mtval write, no redirect.
      env_mtvec = 64'h9000;
      w0 = wr_addr_q.size(); r0 = rd_tgt_q.size();
      acc = cyc;
      io_exc_valid = 1'b1; io_exc_pc = 64'h5000; io_exc_cause = 64'd1; io_exc_tval = 64'h11;
      @(posedge clock); #1;          // W_EPC
      io_exc_valid = 1'b0;
      @(posedge clock); #1;          // W_CAUSE
      reset = 1'b1;
      @(posedge clock); #1;          // back in IDLE
      reset = 1'b0;
      @(negedge clock);
      check("abort wen",    64'(io_csr_wen), 64'd0);
      check("abort addr",   64'(io_csr_addr), 64'd0);
      check("abort wdata",  io_csr_wdata, 64'd0);
      check("abort stall",  64'(io_stall), 64'd0);
      check("abort redir",  64'(io_redir_valid), 64'd0);
      check("abort target", io_redir_target, 64'd0);
      repeat (6) @(posedge clock);
      #1;
      late = 0;
      for (int j = w0; j < wr_addr_q.size(); j++)
         if (wr_cyc_q[j] > acc + 2 || wr_addr_q[j] == 12'h343) late++;
      check("abort late_writes", 64'(late), 64'd0);
      check("abort redirects", 64'(rd_tgt_q.size() - r0), 64'd0);
      $display("txn abort pc=0000000000005000 reset in W_CAUSE");
      run_txn(tbl[0], 100);

      // Randomized transactions against the behavioural model.
      for (int i = 0; i < 40; i++) begin
         kind    = $urandom_range(0, 2);
         rv.exc  = (kind != 1);
         rv.mret = (kind != 0);
         rv.pc   = {$urandom, $urandom};
         rv.cause = {$urandom, $urandom};
         rv.tval  = {$urandom, $urandom};
         rv.csr   = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) rv.csr[1:0] = 2'b01;
         rv.exp_target = model_target(rv.exc, rv.cause, rv.csr);
         rv.inj = ($urandom_range(0, 1) == 1) ?
                  int'($urandom_range(1, rv.exc ? EXC_LAT : MRET_LAT)) : 0;
         run_txn(rv, 200 + i);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
